hit_judge_scheduler: RTL



---
 rtl/guitar_pkg.sv | 17 +
 rtl/hit_judge_scheduler_intersect.sv | 31 +++
 rtl/hit_judge_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/guitar_pkg.sv
// Shared definitions for the note-judging datapath: lane count, note
// coordinate width and the judge FSM state encoding.
package guitar_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned LANE_W    = $clog2(LANES);
    localparam int unsigned Y_W       = 32;
    localparam int unsigned NUM_NOTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } judge_state_e;

endpackage : guitar_pkg

// File: rtl/hit_judge_scheduler_intersect.sv
// Note/bar vertical overlap comparator. Purely combinational; all
// arithmetic is carried at Y_W+1 bits so neither sum can wrap.
module hit_judge_scheduler_intersect #(
    parameter int unsigned Y_W = 32
) (
    input  logic [9:0]     bar_y_i,
    input  logic [9:0]     bar_width_y_i,
    input  logic [6:0]     note_width_y_i,
    input  logic [Y_W-1:0] note_y_i,
    output logic           hit_o
);

    import guitar_pkg::*;

    localparam int unsigned EXT_W = Y_W + 1;

    logic [EXT_W-1:0] bar_top;
    logic [EXT_W-1:0] bar_bot;
    logic [EXT_W-1:0] note_top;
    logic [EXT_W-1:0] note_bot;

    // Overlap when the bar bottom is below the note top and the bar top is above the note bottom.
    always_comb begin
        bar_top  = EXT_W'(bar_y_i);
        bar_bot  = EXT_W'(bar_y_i) + EXT_W'(bar_width_y_i);
        note_top = EXT_W'(note_y_i);
        note_bot = EXT_W'(note_y_i) + EXT_W'(note_width_y_i);
        hit_o    = (bar_bot > note_top) && (bar_top < note_bot);
    end

endmodule : hit_judge_scheduler_intersect

// File: rtl/hit_judge_scheduler.sv
// Per-frame hit judge. On each accepted frame_tick the note table is read
// one slot per cycle; returned slots are checked against the hit bar and
// against the lane presses captured at frame start. Optional feature:
// define JUDGE_COMBO_EN to add the saturating combo counter output.
module hit_judge_scheduler #(
    parameter int unsigned NUM_NOTES = guitar_pkg::NUM_NOTES,
    parameter int unsigned LANES     = guitar_pkg::LANES,
    parameter int unsigned Y_W       = guitar_pkg::Y_W
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           frame_tick,
    input  logic [LANES-1:0]               key_press,
    input  logic [9:0]                     bar_y,
    input  logic [9:0]                     bar_width_y,
    input  logic [6:0]                     note_width_y,
    output logic                           rd_en,
    output logic [$clog2(NUM_NOTES)-1:0]   rd_addr,
    input  logic                           rd_valid,
    input  logic [$clog2(LANES)-1:0]       rd_lane,
    input  logic [Y_W-1:0]                 rd_y,
    output logic                           hit_valid,
    output logic [$clog2(NUM_NOTES)-1:0]   hit_slot,
    output logic [$clog2(LANES)-1:0]       hit_lane,
    output logic                           miss_valid,
    output logic [LANES-1:0]               miss_lanes,
    output logic                           busy,
    output logic                           scan_done,
    output logic                           overrun
`ifdef JUDGE_COMBO_EN
    ,
    output logic [15:0]                    combo
`endif
);

    import guitar_pkg::*;

    localparam int unsigned AW = $clog2(NUM_NOTES);
    localparam int unsigned LW = $clog2(LANES);

    judge_state_e   state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [LANES-1:0] pend_q, pend_d;
    logic [LANES-1:0] snap_q, snap_d;
    logic           overrun_q, overrun_d;
    logic           busy_q, busy_d;
    // A read was issued last cycle, so rd_* carries slot rd_slot_q now.
    logic           inflight_q, inflight_d;
    logic [AW-1:0]  rd_slot_q, rd_slot_d;

    logic           hit_valid_q, hit_valid_d;
    logic [AW-1:0]  hit_slot_q, hit_slot_d;
    logic [LW-1:0]  hit_lane_q, hit_lane_d;
    logic           miss_valid_q, miss_valid_d;
    logic [LANES-1:0] miss_lanes_q, miss_lanes_d;
    logic           scan_done_q, scan_done_d;

    logic           isect;
    logic           lane_hit;

    hit_judge_scheduler_intersect #(
        .Y_W (Y_W)
    ) u_intersect (
        .bar_y_i        (bar_y),
        .bar_width_y_i  (bar_width_y),
        .note_width_y_i (note_width_y),
        .note_y_i       (rd_y),
        .hit_o          (isect)
    );

    // Next-state, snapshot/pending bookkeeping and event generation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pend_d       = pend_q | key_press;
        snap_d       = snap_q;
        overrun_d    = overrun_q;
        inflight_d   = (state_q == ST_SCAN);
        rd_slot_d    = addr_q;
        hit_valid_d  = 1'b0;
        hit_slot_d   = '0;
        hit_lane_d   = '0;
        miss_valid_d = 1'b0;
        miss_lanes_d = '0;
        scan_done_d  = 1'b0;
        lane_hit     = inflight_q && rd_valid && isect && snap_q[rd_lane];

        // Consuming the snapshot bit gives one hit per lane, lowest slot first.
        if (lane_hit) begin
            hit_valid_d     = 1'b1;
            hit_slot_d      = rd_slot_q;
            hit_lane_d      = rd_lane;
            snap_d[rd_lane] = 1'b0;
        end

        if (frame_tick && ((state_q != ST_IDLE) || busy_q)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // busy_q still covers the registered REPORT outputs for one cycle.
                if (frame_tick && !busy_q) begin
                    snap_d  = pend_q | key_press;
                    pend_d  = '0;
                    addr_d  = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (addr_q == AW'(NUM_NOTES - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                miss_valid_d = |snap_q;
                miss_lanes_d = snap_q;
                scan_done_d  = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || (state_q == ST_REPORT);
    end

    // State and output registers; reset abandons any scan in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            pend_q       <= '0;
            snap_q       <= '0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            inflight_q   <= 1'b0;
            rd_slot_q    <= '0;
            hit_valid_q  <= 1'b0;
            hit_slot_q   <= '0;
            hit_lane_q   <= '0;
            miss_valid_q <= 1'b0;
            miss_lanes_q <= '0;
            scan_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pend_q       <= pend_d;
            snap_q       <= snap_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            inflight_q   <= inflight_d;
            rd_slot_q    <= rd_slot_d;
            hit_valid_q  <= hit_valid_d;
            hit_slot_q   <= hit_slot_d;
            hit_lane_q   <= hit_lane_d;
            miss_valid_q <= miss_valid_d;
            miss_lanes_q <= miss_lanes_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign rd_en      = (state_q == ST_SCAN);
    assign rd_addr    = addr_q;
    assign hit_valid  = hit_valid_q;
    assign hit_slot   = hit_slot_q;
    assign hit_lane   = hit_lane_q;
    assign miss_valid = miss_valid_q;
    assign miss_lanes = miss_lanes_q;
    assign busy       = busy_q;
    assign scan_done  = scan_done_q;
    assign overrun    = overrun_q;

`ifdef JUDGE_COMBO_EN
    logic [15:0] combo_q;

    // Combo follows the visible events: reset on a reported miss, else count hits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            combo_q <= '0;
        end else if (miss_valid_q && (miss_lanes_q != '0)) begin
            combo_q <= '0;
        end else if (hit_valid_q && (combo_q != '1)) begin
            combo_q <= combo_q + 16'd1;
        end
    end

    assign combo = combo_q;
`endif

endmodule : hit_judge_scheduler
